// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, ALU/size/writeback encodings and the control bundle
// shared by the ID stage, the ALU and the hazard logic.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_BEQ = 4'd11;
    localparam logic [3:0] ALU_BNE = 4'd12;
    localparam logic [3:0] ALU_BGE = 4'd13;
    localparam logic [3:0] ALU_BLT = 4'd14;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] M2R_PC4 = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_ALU = 2'd2;

    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_JUMP = 2'd2;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] mem_to_reg;
        logic [1:0] jump;
        logic [3:0] alu_op;
        logic [1:0] inst_size;
        logic       is_signed;
        logic [4:0] shift_amount;
        logic       illegal;
    } ctrl_t;

    // Bundle that can never write a register or touch memory (reg_write is active low).
    localparam ctrl_t CTRL_SAFE = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, mem_read: 1'b0,
                                    mem_write: 1'b0, reg_write: 1'b1, alu_src_a: 1'b0,
                                    alu_src_b: 1'b0, mem_to_reg: M2R_PC4, jump: JMP_NONE,
                                    alu_op: ALU_ADD, inst_size: SZ_WORD, is_signed: 1'b0,
                                    shift_amount: 5'd0, illegal: 1'b0};

    function automatic logic [1:0] size_of(input logic [1:0] f3);
        return (f3 == 2'b00) ? SZ_BYTE : (f3 == 2'b01) ? SZ_HALF : SZ_WORD;
    endfunction

    // alt selects SUB over ADD and SRA over SRL.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_decode.sv
// id_decode: combinational RV32I instruction -> control bundle, illegal flag and source usage.
// RV32M_EN adds MUL decoding; without it every funct7=0000001 R-type is illegal.
module id_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o
);

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       bad, m_ok, std_ok;
    ctrl_t      c;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];
    assign std_ok = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101));

`ifdef RV32M_EN
    assign m_ok = (f7 == 7'b0000001) && (f3 == 3'b000);
`else
    assign m_ok = 1'b0;
`endif

    always_comb begin
        c = CTRL_SAFE;
        c.is_signed = 1'b1;
        bad = 1'b0;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        case (opc)
            OP_LUI: begin
                c.rd = inst_i[11:7];
                c.reg_write = 1'b0;
                c.alu_src_b = 1'b1;
                c.mem_to_reg = M2R_ALU;
                c.alu_op = ALU_LUI;
            end
            OP_AUIPC: begin
                c.rd = inst_i[11:7];
                c.reg_write = 1'b0;
                c.alu_src_b = 1'b1;
                c.mem_to_reg = M2R_ALU;
            end
            OP_JAL: begin
                c.rd = inst_i[11:7];
                c.reg_write = 1'b0;
                c.alu_src_b = 1'b1;
                c.jump = JMP_JUMP;
            end
            OP_JALR: begin
                c.rd = inst_i[11:7];
                c.rs1 = inst_i[19:15];
                uses_rs1_o = 1'b1;
                c.reg_write = 1'b0;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                c.jump = JMP_JUMP;
                bad = f3 != 3'b000;
            end
            OP_BRANCH: begin
                c.rs1 = inst_i[19:15];
                c.rs2 = inst_i[24:20];
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_op = f3[2] ? (f3[0] ? ALU_BGE : ALU_BLT) : (f3[0] ? ALU_BNE : ALU_BEQ);
                c.is_signed = !(f3[2] && f3[1]);
                bad = f3[2:1] == 2'b01;
            end
            OP_LOAD: begin
                c.rd = inst_i[11:7];
                c.rs1 = inst_i[19:15];
                uses_rs1_o = 1'b1;
                c.mem_read = 1'b1;
                c.reg_write = 1'b0;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                c.mem_to_reg = M2R_MEM;
                c.inst_size = size_of(f3[1:0]);
                c.is_signed = !f3[2];
                bad = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
            end
            OP_STORE: begin
                c.rs1 = inst_i[19:15];
                c.rs2 = inst_i[24:20];
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                c.mem_write = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                c.inst_size = size_of(f3[1:0]);
                bad = f3[2] || (f3[1:0] == 2'b11);
            end
            OP_IMM: begin
                c.rd = inst_i[11:7];
                c.rs1 = inst_i[19:15];
                uses_rs1_o = 1'b1;
                c.reg_write = 1'b0;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                c.mem_to_reg = M2R_ALU;
                c.alu_op = alu_of(f3, (f3 == 3'b101) && f7[5]);
                c.is_signed = f3 != 3'b011;
                // Only the shift immediates reserve the funct7 bits.
                bad = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                      ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
            end
            OP_REG: begin
                c.rd = inst_i[11:7];
                c.rs1 = inst_i[19:15];
                c.rs2 = inst_i[24:20];
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                c.reg_write = 1'b0;
                c.alu_src_a = 1'b1;
                c.mem_to_reg = M2R_ALU;
                c.alu_op = m_ok ? ALU_MUL : alu_of(f3, f7[5]);
                c.is_signed = f3 != 3'b011;
                bad = !(std_ok || m_ok);
            end
            default: bad = 1'b1;
        endcase
        c.shift_amount = (c.alu_op inside {ALU_SLL, ALU_SRL, ALU_SRA}) ? inst_i[24:20] : 5'd0;
        if (bad) begin
            c = CTRL_SAFE;
            c.illegal = 1'b1;
            c.alu_op = ALU_SUB;
            uses_rs1_o = 1'b0;
            uses_rs2_o = 1'b0;
        end
    end

    assign ctrl_o = c;

endmodule

// File: rtl/id_pipe_control.sv
// id_pipe_control: registered ID stage with valid/ready handshake, load-use bubble,
// flush and a saturating stall counter. Decoding lives in id_decode (RV32M_EN there).
module id_pipe_control
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       jump,
    output logic [3:0]       alu_op,
    output logic [1:0]       inst_size,
    output logic             is_signed,
    output logic [4:0]       shift_amount,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_t            dec, ctrl_q, ctrl_d;
    logic             valid_q, valid_d, uses_rs1, uses_rs2, hazard, accept;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    id_decode u_decode (
        .inst_i    (inst),
        .ctrl_o    (dec),
        .uses_rs1_o(uses_rs1),
        .uses_rs2_o(uses_rs2)
    );

    // A load to x0 is harmless; only a real destination can stall the consumer.
    assign hazard = valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) && in_valid &&
                    ((uses_rs1 && (inst[19:15] == ctrl_q.rd)) || (uses_rs2 && (inst[24:20] == ctrl_q.rd)));
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush || (out_ready && !accept)) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_SAFE;
            pc_d    = '0;
        end
        if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            pc_d    = pc;
        end
        if (hazard && out_ready && !flush && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_SAFE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign rs1          = ctrl_q.rs1;
    assign rs2          = ctrl_q.rs2;
    assign rd           = ctrl_q.rd;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign reg_write    = ctrl_q.reg_write;
    assign alu_src_a    = ctrl_q.alu_src_a;
    assign alu_src_b    = ctrl_q.alu_src_b;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign jump         = ctrl_q.jump;
    assign alu_op       = ctrl_q.alu_op;
    assign inst_size    = ctrl_q.inst_size;
    assign is_signed    = ctrl_q.is_signed;
    assign shift_amount = ctrl_q.shift_amount;
    assign illegal      = ctrl_q.illegal;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_pipe_control.sv
// tb_id_pipe_control: directed stimulus, per-cycle comparison against a behavioural
// model of the ID stage, plus hand-computed pins on key cycles.
module tb_id_pipe_control;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] inst, pc;
    logic        in_ready, out_valid, mem_read, mem_write, reg_write, alu_src_a, alu_src_b;
    logic        is_signed, illegal;
    logic [31:0] out_pc;
    logic [4:0]  rs1, rs2, rd, shift_amount;
    logic [1:0]  mem_to_reg, jump, inst_size;
    logic [3:0]  alu_op;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    id_pipe_control #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .mem_to_reg(mem_to_reg), .jump(jump), .alu_op(alu_op), .inst_size(inst_size),
        .is_signed(is_signed), .shift_amount(shift_amount), .illegal(illegal),
        .stall_count(stall_count)
    );

    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       mr, mw, rw, sa, sb;
        logic [1:0] m2r, jmp;
        logic [3:0] alu;
        logic [1:0] sz;
        logic       sg;
        logic [4:0] sh;
        logic       ill, u1, u2;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t safe_e();
        exp_t e;
        e = '0;
        e.rw = 1'b1;
        return e;
    endfunction

    // Expected decode straight from the instruction-set rules.
    function automatic exp_t md(input logic [31:0] i);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic ok;
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd6, 4'd9, 4'd9, 4'd5, 4'd7, 4'd4, 4'd3};
        op = i[6:0];
        f7 = i[31:25];
        f3 = i[14:12];
        e = '0;
        e.sg = 1'b1;
        e.rw = 1'b1;
        ok = 1'b0;
        case (op)
            7'h37: begin ok = 1; e.rd = i[11:7]; e.rw = 0; e.sb = 1; e.m2r = 2'd2; e.alu = 4'd10; end
            7'h17: begin ok = 1; e.rd = i[11:7]; e.rw = 0; e.sb = 1; e.m2r = 2'd2; end
            7'h6F: begin ok = 1; e.rd = i[11:7]; e.rw = 0; e.sb = 1; e.jmp = 2'd2; end
            7'h67: begin
                ok = (f3 == 3'd0); e.rd = i[11:7]; e.rs1 = i[19:15]; e.u1 = 1;
                e.rw = 0; e.sa = 1; e.sb = 1; e.jmp = 2'd2;
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.u1 = 1; e.rw = 0; e.mr = 1;
                e.sa = 1; e.sb = 1; e.m2r = 2'd1;
                e.sz = (f3[1:0] == 2'd0) ? 2'd2 : (f3[1:0] == 2'd1) ? 2'd1 : 2'd0;
                e.sg = (f3 < 3'd4);
            end
            7'h23: begin
                ok = (f3 < 3'd3); e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.u1 = 1; e.u2 = 1;
                e.mw = 1; e.sa = 1; e.sb = 1;
                e.sz = (f3[1:0] == 2'd0) ? 2'd2 : (f3[1:0] == 2'd1) ? 2'd1 : 2'd0;
            end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3}); e.rs1 = i[19:15]; e.rs2 = i[24:20];
                e.u1 = 1; e.u2 = 1; e.sa = 1;
                e.alu = (f3 == 3'd0) ? 4'd11 : (f3 == 3'd1) ? 4'd12 : f3[0] ? 4'd13 : 4'd14;
                e.sg = (f3 < 3'd6);
            end
            7'h13: begin
                ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.u1 = 1; e.rw = 0; e.sa = 1; e.sb = 1; e.m2r = 2'd2;
                e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd8 : tab[f3];
                e.sg = (f3 != 3'd3);
            end
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.u1 = 1; e.u2 = 1;
                e.rw = 0; e.sa = 1; e.m2r = 2'd2;
                e.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd1 : 4'd8) : tab[f3];
                e.sg = (f3 != 3'd3);
`ifdef RV32M_EN
                if (f7 == 7'h01 && f3 == 3'd0) begin ok = 1; e.alu = 4'd2; end
`endif
            end
            default: ok = 1'b0;
        endcase
        if ((op == 7'h13 || op == 7'h33) && e.alu inside {4'd6, 4'd7, 4'd8}) e.sh = i[24:20];
        if (!ok) begin
            e = safe_e();
            e.ill = 1'b1;
            e.alu = 4'd1;
        end
        return e;
    endfunction

    logic        m_valid;
    exp_t        m_e;
    logic [31:0] m_pc;
    int          m_cnt;

    function automatic logic m_haz();
        exp_t d;
        d = md(inst);
        return m_valid && m_e.mr && (m_e.rd != 5'd0) && in_valid &&
               ((d.u1 && inst[19:15] == m_e.rd) || (d.u2 && inst[24:20] == m_e.rd));
    endfunction

    function automatic logic m_rdy();
        return (!m_valid || out_ready) && !m_haz() && !flush;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0; m_e <= safe_e(); m_pc <= '0; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 1'b0; m_e <= safe_e(); m_pc <= '0;
        end else if (in_valid && m_rdy()) begin
            m_valid <= 1'b1; m_e <= md(inst); m_pc <= pc;
        end else if (out_ready) begin
            m_valid <= 1'b0; m_e <= safe_e(); m_pc <= '0;
            if (m_haz() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
        end
    end

    logic [36:0] dut_b;
    assign dut_b = {rs1, rs2, rd, mem_read, mem_write, reg_write, alu_src_a, alu_src_b,
                    mem_to_reg, jump, alu_op, inst_size, is_signed, shift_amount, illegal};

    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("bundle", dut_b, m_e[38:2]);
        chk("out_pc", out_pc, m_pc);
        chk("stall_count", stall_count, m_cnt);
        chk("in_ready", in_ready, m_rdy());
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] p);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; inst = ins; pc = p;
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
        end
        chk("accept", acc, 1);
        in_valid = 1'b0;
    endtask

    logic [31:0] misc [12];

    initial begin
        misc = '{32'h123452B7, 32'h00001317, 32'h00008067, 32'h0000D203, 32'h0050B393, 32'h401101B3,
                 32'h40309293, 32'h021141B3, 32'h001111B3, 32'h0000000F, 32'h0020C463, 32'h00209023};
        reset = 1'b1; in_valid = 0; inst = 0; pc = 0; flush = 0; out_ready = 1;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0); chk("rst_reg_write", reg_write, 1);
        chk("rst_mem_read", mem_read, 0); chk("rst_illegal", illegal, 0);
        chk("rst_stall", stall_count, 0);
        tick(); tick();
        reset = 1'b1;
        // addi x1,x0,5
        in_valid = 1; inst = 32'h00500093; pc = 32'h100;
        tick();
        in_valid = 0;
        chk("addi_valid", out_valid, 1); chk("addi_rd", rd, 1); chk("addi_alu", alu_op, 0);
        chk("addi_srcb", alu_src_b, 1); chk("addi_m2r", mem_to_reg, 2); chk("addi_rw", reg_write, 0);
        chk("addi_pc", out_pc, 32'h100);
        tick();
        chk("drain_valid", out_valid, 0);
        // lw x2 then dependent add
        send(32'h0000A103, 32'h104);
        chk("lw_mr", mem_read, 1); chk("lw_rd", rd, 2);
        in_valid = 1; inst = 32'h001101B3; pc = 32'h108;
        #1 chk("haz_ready", in_ready, 0);
        tick();
        chk("bubble_valid", out_valid, 0); chk("bubble_rw", reg_write, 1); chk("bubble_cnt", stall_count, 1);
        tick();
        in_valid = 0;
        chk("add_valid", out_valid, 1); chk("add_rd", rd, 3); chk("add_rs1", rs1, 2);
        // load to x0 never stalls
        send(32'h0000A003, 32'h10C);
        chk("lw0_rd", rd, 0);
        in_valid = 1; inst = 32'h001001B3; pc = 32'h110;
        #1 chk("x0_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("x0_valid", out_valid, 1); chk("x0_cnt", stall_count, 1);
        // hold srai for three cycles
        send(32'h4030D293, 32'h114);
        out_ready = 0; in_valid = 1; inst = 32'h00500093;
        repeat (3) begin
            tick();
            chk("hold_valid", out_valid, 1); chk("hold_alu", alu_op, 8); chk("hold_sh", shift_amount, 3);
            chk("hold_rd", rd, 5); chk("hold_ready", in_ready, 0); chk("hold_pc", out_pc, 32'h114);
        end
        flush = 1;
        #1 chk("flush_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("flush_valid", out_valid, 0); chk("flush_rw", reg_write, 1);
        // reset in the middle of a load-use stall
        send(32'h0000A103, 32'h118);
        in_valid = 1; inst = 32'h001101B3;
        #1 reset = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0); chk("mid_mr", mem_read, 0); chk("mid_rw", reg_write, 1);
        chk("mid_rd", rd, 0); chk("mid_cnt", stall_count, 0); chk("mid_pc", out_pc, 0);
        in_valid = 0;
        tick();
        reset = 1'b1;
        // mul
        send(32'h021101B3, 32'h200);
`ifdef RV32M_EN
        chk("mul_alu", alu_op, 2); chk("mul_ill", illegal, 0); chk("mul_rw", reg_write, 0);
`else
        chk("mul_alu", alu_op, 1); chk("mul_ill", illegal, 1); chk("mul_rw", reg_write, 1);
`endif
        chk("mul_valid", out_valid, 1);
        send(32'h0020A023, 32'h204);
        chk("sw_mw", mem_write, 1); chk("sw_rw", reg_write, 1); chk("sw_sz", inst_size, 0); chk("sw_rs2", rs2, 2);
        send(32'h0020E463, 32'h208);
        chk("bltu_alu", alu_op, 14); chk("bltu_sg", is_signed, 0); chk("bltu_rw", reg_write, 1);
        send(32'h0000C203, 32'h20C);
        chk("lbu_sz", inst_size, 2); chk("lbu_sg", is_signed, 0); chk("lbu_mr", mem_read, 1);
        send(32'h008000EF, 32'h210);
        chk("jal_jump", jump, 2); chk("jal_m2r", mem_to_reg, 0); chk("jal_rd", rd, 1);
        send(32'h00000073, 32'h214);
        chk("ecall_ill", illegal, 1); chk("ecall_alu", alu_op, 1); chk("ecall_valid", out_valid, 1);
        for (int n = 0; n < 12; n++) send(misc[n], 32'h300 + 4 * n);
        // store data dependency stalls via rs2
        send(32'h0000A103, 32'h400);
        send(32'h0020A023, 32'h404);
        chk("sw_haz_cnt", stall_count, 1);
        // flush beats a hazard and does not count
        send(32'h0000A103, 32'h408);
        in_valid = 1; inst = 32'h001101B3; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("flush_haz_cnt", stall_count, 1); chk("flush_haz_valid", out_valid, 0);
        repeat (16) begin
            send(32'h0000A103, 32'h500);
            send(32'h001101B3, 32'h504);
        end
        chk("sat_cnt", stall_count, CMAX);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_pipe_control.md
Name: id_pipe_control

Overview:
Registered, parametrised decode and control stage between IF and EX of the RV32I core.
- Decodes one instruction per cycle into the existing control bundle and holds it in a single pipeline register.
- Uses a valid/ready handshake on both sides.
- Detects load-use hazards against the instruction it holds and inserts a bubble.
- Supports flush and counts hazard stalls.

Parameters:
XLEN, 32, width of PC carried with the instruction
CNT_W, 16, width of the saturating hazard-stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  IF presents inst/pc
in_ready  out  1  stage accepts inst this cycle
inst  in  32  instruction word
pc  in  XLEN  PC of inst
flush  in  1  kill held and incoming instruction (branch/jump redirect)
out_valid  out  1  control bundle valid to EX
out_ready  in  1  EX accepts bundle
out_pc  out  XLEN  registered PC
rs1, rs2, rd  out  5 each  registered register indices
mem_read, mem_write  out  1 each  data memory enables
reg_write  out  1  register-file write enable, active low
alu_src_a  out  1  0=pc, 1=rs1
alu_src_b  out  1  0=rs2, 1=sext immediate
mem_to_reg  out  2  0=pc+4, 1=mem data, 2=alu
jump  out  2  2=jal/jalr, 0 otherwise
alu_op  out  4  ALU op: ADD0 SUB1 MUL2 AND3 OR4 XOR5 SLL6 SRL7 SRA8 SLT9 LUI10 BEQ11 BNE12 BGE13 BLT14
inst_size  out  2  00=word, 01=half, 10=byte
is_signed  out  1  0 for lbu/lhu/sltu/sltiu/bltu/bgeu
shift_amount  out  5  inst[24:20] for shifts, else 0
illegal  out  1  unsupported opcode/funct
stall_count  out  CNT_W  saturating load-use stall count

Behaviour:
- Reset (async, reset=0):
  - out_valid=0, mem_read=0, mem_write=0, reg_write=1, illegal=0.
  - All other registered outputs 0; stall_count=0.
  - No X on any registered output.
- Hazard:
  - hazard = out_valid & mem_read & rd!=0 & in_valid & ((uses_rs1 & inst.rs1==rd) | (uses_rs2 & inst.rs2==rd)).
  - uses_rs1: all except LUI/AUIPC/JAL.
  - uses_rs2: R-type, STORE, BRANCH.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept: in_valid & in_ready → next cycle the register holds the decoded bundle and out_valid=1. Latency is 1 cycle.
- Hold: out_valid & !out_ready → all outputs stable.
- Bubble: hazard & out_ready → next cycle out_valid=0 with a safe bundle (mem_read=0, mem_write=0, reg_write=1). stall_count increments once per bubble and saturates at 2^CNT_W-1.
- Flush:
  - Next cycle out_valid=0, safe bundle, incoming inst dropped (in_ready=0).
  - Flush dominates hazard and accept; no stall_count increment.
- Drain: out_ready & !accept → out_valid=0 next cycle.
- Illegal opcode or funct:
  - illegal=1, out_valid=1, reg_write=1, mem_read=0, mem_write=0, alu_op=SUB.
  - The instruction still flows so the trap logic in EX can see it.
- Decode table:
  - LUI: reg_write=0, src_b=1, m2r=2, alu=LUI.
  - AUIPC: src_a=0, src_b=1, m2r=2, ADD.
  - IMM: src_a=1, src_b=1, m2r=2.
  - LOAD: mem_read=1, m2r=1, ADD.
  - STORE: mem_write=1, reg_write=1, ADD.
  - R-type: src_b=0, m2r=2.
  - BRANCH: reg_write=1, src_b=0.
  - JAL: src_a=0, src_b=1, m2r=0, jump=2.
  - JALR: src_a=1, src_b=1, m2r=0, jump=2.
  - Don't-care fields register as 0.
- rd=0 with reg_write=0 is legal; downstream suppresses the write. A load to x0 never causes a hazard.

Optional Feature:
RV32M_EN
- Defined: R-type with funct7=0000001 and f3=000 (MUL) decodes to alu_op=MUL(2), illegal=0. Other M funct3 values are illegal.
- Undefined: any funct7=0000001 is illegal.

Decomposition:
- Package riscv_ctrl_pkg holds shared constants used by id_pipe_control, ALU and hazard logic:
  - opcode localparams
  - ALU op codes
  - size codes
  - mem_to_reg and jump encodings
- Sub-module id_decode: purely combinational inst → bundle + illegal + uses_rs1/uses_rs2. id_pipe_control owns the register, handshake, hazard, flush and counter.

Test Plan:
1. addi x1,x0,5 (0x00500093) with out_ready=1 → 1 cycle later: out_valid=1, rd=1, alu_op=0, src_b=1, m2r=2, reg_write=0.
2. lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3) → add stalls one cycle, bubble (out_valid=0, reg_write=1), then add issues; stall_count=1.
3. lw x0,0(x1) (0x0000A003) then add x3,x0,x1 → no bubble; stall_count unchanged.
4. out_ready=0 for 3 cycles with srai x5,x1,3 (0x4030D293) held → outputs stable, alu_op=8, shift_amount=3, in_ready=0.
5. flush asserted with valid held bundle and in_valid=1 → next cycle out_valid=0, inst dropped; reset asserted mid-stall → all outputs at reset values immediately.
6. mul x3,x2,x1 (0x021101B3) → alu_op=2, illegal=0 with RV32M_EN; illegal=1, reg_write=1 without.
